// File: rtl/countdown_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_sched_pkg
// Brief    : Shared types and constants for the countdown scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package countdown_sched_pkg;

    // Width of the shared load/count-down counter and of each delay field.
    localparam int CW_DEFAULT = 3;

    // Scheduler states; encodings are fixed so the state is readable on a bus.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        ACK   = 2'd3
    } state_t;

endpackage : countdown_sched_pkg
`default_nettype wire

// File: rtl/countdown_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Returns the first asserted
//            request at or after the pointer, wrapping around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     grant,
    output logic               valid
);

    // Scan from the farthest offset back to the pointer so the nearest
    // asserted request (smallest offset from the pointer) is the last written.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            automatic int idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                grant = IDW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/countdown_sched.sv
`default_nettype none
// ============================================================================
// Module   : countdown_sched
// Brief    : Round-robin scheduler sharing one load/count-down counter among
//            NUM_REQ requesters. Grants a requester, loads its delay into the
//            counter, counts until done, then pulses that requester's ack.
//            Optional macro COUNTDOWN_SCHED_PAUSE_EN adds a pause input that
//            freezes counting while in COUNT.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_sched
    import countdown_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int CW      = CW_DEFAULT,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*CW-1:0] req_delay,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic                  ctr_load,
    output logic [CW-1:0]         ctr_count_to,
    output logic                  ctr_count_en,
`ifdef COUNTDOWN_SCHED_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic                  ctr_done
);

    state_t               state_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_d;
    logic [IDW-1:0]       grant_q;
    logic [CW-1:0]        count_to_q;
    logic                 load_q;
    logic                 busy_q;
    logic [NUM_REQ-1:0]   ack_q;

    logic [IDW-1:0]       arb_grant;
    logic                 arb_valid;
    logic [CW-1:0]        sel_delay;
    logic                 count_hold;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign sel_delay = req_delay[int'(arb_grant)*CW +: CW];

`ifdef COUNTDOWN_SCHED_PAUSE_EN
    assign count_hold = pause;
`else
    assign count_hold = 1'b0;
`endif

    // Pointer moves to the slot just past the winner, wrapping at the top.
    always_comb begin
        if (arb_grant == IDW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = arb_grant + 1'b1;
        end
    end

    // Count enable is combinational so the counter stops on the very cycle
    // it reports done; a stale done outside COUNT is ignored.
    always_comb begin
        ctr_count_en = (state_q == COUNT) && !ctr_done && !count_hold;
    end

    // Scheduler FSM with registered load/ack/busy/grant outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            count_to_q <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
        end else begin
            load_q <= 1'b0;
            ack_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q    <= arb_grant;
                        count_to_q <= sel_delay;
                        ptr_q      <= ptr_d;
                        load_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= COUNT;
                end
                COUNT: begin
                    if (ctr_done && !count_hold) begin
                        ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack          = ack_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign ctr_load     = load_q;
    assign ctr_count_to = count_to_q;

endmodule : countdown_sched
`default_nettype wire

// File: tb/tb_countdown_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_sched
// Brief    : Directed self-checking bench for countdown_sched, including a
//            behavioural model of the shared count-down counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_sched;

    localparam int NUM_REQ = 4;
    localparam int CW      = 3;
    localparam int IDW     = 2;

    logic                  clk       = 1'b0;
    logic                  reset_n   = 1'b0;
    logic [NUM_REQ-1:0]    req       = '0;
    logic [NUM_REQ*CW-1:0] req_delay = '0;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic [IDW-1:0]        grant_id;
    logic                  ctr_load;
    logic [CW-1:0]         ctr_count_to;
    logic                  ctr_count_en;
    logic                  ctr_done;
`ifdef COUNTDOWN_SCHED_PAUSE_EN
    logic                  pause     = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    countdown_sched #(
        .NUM_REQ (NUM_REQ),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_delay    (req_delay),
        .ack          (ack),
        .busy         (busy),
        .grant_id     (grant_id),
        .ctr_load     (ctr_load),
        .ctr_count_to (ctr_count_to),
        .ctr_count_en (ctr_count_en),
`ifdef COUNTDOWN_SCHED_PAUSE_EN
        .pause        (pause),
`endif
        .ctr_done     (ctr_done)
    );

    always #5 clk = ~clk;

    // Shared counter: load clears done; each enabled cycle decrements, and an
    // enabled cycle at zero raises done, giving D+1 enabled cycles per job.
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            ctr_done <= 1'b0;
        end else if (ctr_load) begin
            cnt_q    <= ctr_count_to;
            ctr_done <= 1'b0;
        end else if (ctr_count_en) begin
            if (cnt_q == '0) ctr_done <= 1'b1;
            else             cnt_q    <= cnt_q - 1'b1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int idx, input int d);
        req_delay[idx*CW +: CW] = CW'(d);
    endtask

    // Inputs for cycle t are already applied; k counts cycles after t.
    task automatic observe_job(output int ack_k, output int ack_v, output int load_k,
                               output int load_n, output int en_n, output int gid,
                               output int cto);
        ack_k = -1; ack_v = 0; load_k = -1; load_n = 0; en_n = 0; gid = -1; cto = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            @(negedge clk);
            if (k == 1) begin
                gid = int'(grant_id);
                cto = int'(ctr_count_to);
            end
            if (ctr_load) begin
                load_n++;
                if (load_k < 0) load_k = k;
            end
            if (ctr_count_en) en_n++;
            if (ack != '0) begin
                ack_k = k;
                ack_v = int'(ack);
                break;
            end
        end
    endtask

    int ack_k, ack_v, load_k, load_n, en_n, gid, cto;
    int seen;
    int rr_k[5];
    int rr_v[5];
    int rr_n;

    initial begin
        // Reset with all requests asserted
        req = 4'b1111;
        tick(); tick(); tick();
        @(negedge clk);
        check("rst_ack",      int'(ack),          0);
        check("rst_busy",     int'(busy),         0);
        check("rst_grant",    int'(grant_id),     0);
        check("rst_load",     int'(ctr_load),     0);
        check("rst_count_to", int'(ctr_count_to), 0);
        check("rst_count_en", int'(ctr_count_en), 0);

        // Single requester 0, delay 3: ack at t+7, 4 enabled cycles
        tick();
        reset_n = 1'b1;
        req     = 4'b0001;
        set_delay(0, 3);
        observe_job(ack_k, ack_v, load_k, load_n, en_n, gid, cto);
        check("j0_ack_cycle", ack_k,  7);
        check("j0_ack_val",   ack_v,  1);
        check("j0_load_cycle", load_k, 1);
        check("j0_load_count", load_n, 1);
        check("j0_en_count",  en_n,   4);
        check("j0_grant",     gid,    0);
        check("j0_count_to",  cto,    3);
        tick();
        req = '0;
        @(negedge clk);
        check("j0_idle_busy", int'(busy), 0);
        check("j0_idle_ack",  int'(ack),  0);

        // Zero delay on requester 2: ack at t+4, one enabled cycle
        tick();
        req = 4'b0100;
        set_delay(2, 0);
        observe_job(ack_k, ack_v, load_k, load_n, en_n, gid, cto);
        check("z_ack_cycle", ack_k, 4);
        check("z_ack_val",   ack_v, 4);
        check("z_en_count",  en_n,  1);
        check("z_grant",     gid,   2);

        // Pointer at 3: requests 3 and 0 -> grant 3 then wrap to 0
        tick();
        req = 4'b1001;
        set_delay(3, 1);
        observe_job(ack_k, ack_v, load_k, load_n, en_n, gid, cto);
        check("wrap_grant_a", gid,   3);
        check("wrap_ack_a",   ack_v, 8);
        check("wrap_cycle_a", ack_k, 5);
        tick();
        req = 4'b0001;
        observe_job(ack_k, ack_v, load_k, load_n, en_n, gid, cto);
        check("wrap_grant_b", gid,   0);
        check("wrap_ack_b",   ack_v, 1);
        check("wrap_cycle_b", ack_k, 7);
        tick();
        req = '0;

        // Reset in the middle of COUNT with delay 7
        tick();
        req = 4'b0010;
        set_delay(1, 7);
        tick(); tick(); tick();
        tick();
        check("mid_busy_pre", int'(busy),         1);
        check("mid_en_pre",   int'(ctr_count_en), 1);
        reset_n = 1'b0;
        #1;
        check("mid_busy",     int'(busy),         0);
        check("mid_en",       int'(ctr_count_en), 0);
        check("mid_grant",    int'(grant_id),     0);
        check("mid_count_to", int'(ctr_count_to), 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack != '0) seen++;
        end
        check("mid_no_ack", seen, 0);
        tick();
        reset_n = 1'b1;
        observe_job(ack_k, ack_v, load_k, load_n, en_n, gid, cto);
        check("post_grant",     gid,   1);
        check("post_ack_val",   ack_v, 2);
        check("post_ack_cycle", ack_k, 11);
        check("post_en_count",  en_n,  8);
        tick();
        req = '0;

        // Round-robin with all requests held, delay 1 each
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req     = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_delay(i, 1);
        rr_n = 0;
        for (int k = 1; k <= 60 && rr_n < 5; k++) begin
            tick();
            @(negedge clk);
            if (ack != '0) begin
                rr_k[rr_n] = k;
                rr_v[rr_n] = int'(ack);
                rr_n++;
            end
        end
        check("rr_ack_count", rr_n, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rr_n) begin
                check($sformatf("rr_val_%0d", i), rr_v[i], 1 << (i % NUM_REQ));
                if (i == 0) check("rr_first_cycle", rr_k[0], 5);
                else        check($sformatf("rr_gap_%0d", i), rr_k[i] - rr_k[i-1], 6);
            end
        end
        tick();
        req = '0;

`ifdef COUNTDOWN_SCHED_PAUSE_EN
        // Pause for 3 cycles in COUNT with delay 2: ack at t+9
        tick();
        req = 4'b0001;
        set_delay(0, 2);
        ack_k = -1;
        en_n  = 0;
        seen  = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            pause = (k >= 3 && k <= 5);
            @(negedge clk);
            if (ctr_count_en) en_n++;
            if (pause && ctr_count_en) seen++;
            if (ack != '0) begin
                ack_k = k;
                break;
            end
        end
        pause = 1'b0;
        check("pause_ack_cycle", ack_k, 9);
        check("pause_en_count",  en_n,  3);
        check("pause_en_low",    seen,  0);
        tick();
        req = '0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_countdown_sched
`default_nettype wire
